// File: rtl/neuron_buffer_pingpong_ctrl.sv
// Sequencer for the N1/N2 ping-pong neuron buffers. Each pass streams read
// addresses 0..numWords-1 and writes each result back at the same address
// LAT cycles later, then optionally swaps buffer roles.
// Latency: a pass takes numWords+LAT+1 unstalled cycles from start sample to done.
// Backpressure: i_stall freezes address generation, the delay line and the drain counter.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               begin a pass (IDLE only); latches i_numWords, i_doPoolingIn, i_swapEn
//   i_stall               freeze the pass pipeline
//   i_ioEn/i_ioAddress/i_ioWrite  host access to the read buffer (IDLE only)
//   o_readBufferSelect    0: N1 is the read buffer, 1: N2
//   o_doPooling           pooling mode latched at start
//   o_readBuffAddress     read-buffer address (pass counter or host address)
//   o_writeBuffAddress    write-buffer address (delay-line head)
//   o_nRWrite / o_nWWrite read-/write-buffer write enables
//   o_busy / o_done       not-IDLE flag, one-cycle end-of-pass pulse
module neuron_buffer_pingpong_ctrl #(
    parameter int A   = 7,
    parameter int LAT = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [A-1:0] i_numWords,
    input  logic         i_doPoolingIn,
    input  logic         i_swapEn,
    input  logic         i_stall,
    input  logic         i_ioEn,
    input  logic [A-1:0] i_ioAddress,
    input  logic         i_ioWrite,
    output logic         o_readBufferSelect,
    output logic         o_doPooling,
    output logic [A-1:0] o_readBuffAddress,
    output logic [A-1:0] o_writeBuffAddress,
    output logic         o_nRWrite,
    output logic         o_nWWrite,
    output logic         o_busy,
    output logic         o_done
);

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [A-1:0]  r_numWords;
    logic [A-1:0]  r_rdCnt;
    logic [DW-1:0] r_drainCnt;
    logic          r_swapEn;
    logic          r_doPooling;
    logic          r_rbSel;

    // Delay line: entry 0 is the tail (newest), entry LAT-1 the head.
    logic [LAT-1:0] r_dlVld;
    logic [A-1:0]   r_dlAddr [LAT];

    logic w_advance;
    logic w_pushVld;
    logic w_lastRead;

    assign w_advance  = ~i_stall & ((r_state == S_READ) || (r_state == S_DRAIN));
    assign w_pushVld  = (r_state == S_READ);
    assign w_lastRead = (r_rdCnt == (r_numWords - A'(1)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dlVld <= '0;
            for (int i = 0; i < LAT; i++) r_dlAddr[i] <= '0;
        end else if (w_advance) begin
            for (int i = LAT - 1; i > 0; i--) begin
                r_dlVld[i]  <= r_dlVld[i-1];
                r_dlAddr[i] <= r_dlAddr[i-1];
            end
            r_dlVld[0]  <= w_pushVld;
            r_dlAddr[0] <= w_pushVld ? r_rdCnt : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_numWords  <= '0;
            r_rdCnt     <= '0;
            r_drainCnt  <= '0;
            r_swapEn    <= 1'b0;
            r_doPooling <= 1'b0;
            r_rbSel     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_numWords  <= i_numWords;
                        r_swapEn    <= i_swapEn;
                        r_doPooling <= i_doPoolingIn;
                        r_rdCnt     <= '0;
                        r_drainCnt  <= '0;
                        // An empty pass skips straight to the swap/done cycle.
                        r_state     <= (i_numWords != '0) ? S_READ : S_SWAP;
                    end
                end
                S_READ: begin
                    if (!i_stall) begin
                        r_rdCnt <= r_rdCnt + A'(1);
                        if (w_lastRead) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last valid entry reaches the head after LAT-1 further
                    // shifts and leaves on the next unstalled edge.
                    if (!i_stall) begin
                        if (r_drainCnt == DRAIN_LAST) r_state <= S_SWAP;
                        else                          r_drainCnt <= r_drainCnt + DW'(1);
                    end
                end
                S_SWAP: begin
                    if (r_swapEn) r_rbSel <= ~r_rbSel;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_readBuffAddress = '0;
        o_nRWrite         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // start wins over a simultaneous host access.
                if (i_ioEn && !i_start) begin
                    o_readBuffAddress = i_ioAddress;
                    o_nRWrite         = i_ioWrite;
                end
            end
            S_READ:  o_readBuffAddress = r_rdCnt;
            default: o_readBuffAddress = '0;
        endcase
    end

    assign o_nWWrite          = r_dlVld[LAT-1] & ~i_stall;
    assign o_writeBuffAddress = r_dlAddr[LAT-1];
    assign o_readBufferSelect = r_rbSel;
    assign o_doPooling        = r_doPooling;
    assign o_busy             = (r_state != S_IDLE);
    assign o_done             = (r_state == S_SWAP);

endmodule

// File: tb/tb_neuron_buffer_pingpong_ctrl.sv
// Scoreboard bench for neuron_buffer_pingpong_ctrl.
// Latency: expected write/done events carry the cycle they must appear in.
// Backpressure: stall is driven directly by the directed sequences.
module tb_neuron_buffer_pingpong_ctrl;
    localparam int A   = 7;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [A-1:0] numWords;
    logic         doPoolingIn;
    logic         swapEn;
    logic         stall;
    logic         ioEn;
    logic [A-1:0] ioAddress;
    logic         ioWrite;
    logic         rbSel;
    logic         doPooling;
    logic [A-1:0] rdAddr;
    logic [A-1:0] wrAddr;
    logic         nRWrite;
    logic         nWWrite;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    neuron_buffer_pingpong_ctrl #(.A(A), .LAT(LAT)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_start            (start),
        .i_numWords         (numWords),
        .i_doPoolingIn      (doPoolingIn),
        .i_swapEn           (swapEn),
        .i_stall            (stall),
        .i_ioEn             (ioEn),
        .i_ioAddress        (ioAddress),
        .i_ioWrite          (ioWrite),
        .o_readBufferSelect (rbSel),
        .o_doPooling        (doPooling),
        .o_readBuffAddress  (rdAddr),
        .o_writeBuffAddress (wrAddr),
        .o_nRWrite          (nRWrite),
        .o_nWWrite          (nWWrite),
        .o_busy             (busy),
        .o_done             (done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = write-buffer write, kind 1 = done pulse
    typedef struct packed {
        logic         kind;
        logic [A-1:0] addr;
        logic [31:0]  cyc;
    } ev_t;

    ev_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_write(input int a, input int c);
        ev_t e;
        e.kind = 1'b0;
        e.addr = A'(a);
        e.cyc  = 32'(c);
        sbq.push_back(e);
    endtask

    task automatic exp_done(input int c);
        ev_t e;
        e.kind = 1'b1;
        e.addr = '0;
        e.cyc  = 32'(c);
        sbq.push_back(e);
    endtask

    // Unstalled pass from start sample in cycle k; 'extra' stalled cycles
    // occur before the first write.
    task automatic exp_pass(input int k, input int n, input int extra);
        for (int i = 0; i < n; i++) exp_write(i, k + LAT + 1 + i + extra);
        exp_done(k + n + LAT + 1 + extra);
    endtask

    task automatic mon_event(input logic kind, input logic [A-1:0] a);
        ev_t got;
        ev_t e;
        got.kind = kind;
        got.addr = a;
        got.cyc  = 32'(cyc);
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual kind=%0d addr=%0d cycle=%0d required none", kind, a, cyc);
        end else begin
            e = sbq.pop_front();
            chk("sb_event{kind,addr,cycle}", 64'(got), 64'(e));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (nWWrite === 1'b1) mon_event(1'b0, wrAddr);
            if (done === 1'b1)    mon_event(1'b1, '0);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=expired required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance to the negedge of cycle c (must not already be past it).
    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic start_pass(input int n, input bit pool, input bit sw, output int k);
        tick();
        start       = 1'b1;
        numWords    = A'(n);
        doPoolingIn = pool;
        swapEn      = sw;
        k           = cyc;
    endtask

    int k;
    int k2;

    initial begin
        reset = 1'b1; start = 1'b0; numWords = '0; doPoolingIn = 1'b0; swapEn = 1'b0;
        stall = 1'b0; ioEn = 1'b0; ioAddress = '0; ioWrite = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_rbSel",  rbSel, 0);
        chk("rst_nWWrite", nWWrite, 0);
        chk("rst_nRWrite", nRWrite, 0);
        chk("rst_rdAddr", rdAddr, 0);
        chk("rst_wrAddr", wrAddr, 0);
        chk("rst_doPooling", doPooling, 0);

        // 1: N=4, swap, no stall
        start_pass(4, 1'b1, 1'b1, k);
        exp_pass(k, 4, 0);
        tick(); start = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            wait_neg(k + j);
            chk("t1_rdAddr", rdAddr, j - 1);
        end
        chk("t1_busy", busy, 1);
        chk("t1_doPooling", doPooling, 1);
        wait_neg(k + 8);
        chk("t1_rbSel_at_done", rbSel, 0);
        wait_neg(k + 9);
        chk("t1_rbSel_after", rbSel, 1);
        chk("t1_idle", busy, 0);

        // 2: stall in cycles 2-3
        start_pass(4, 1'b0, 1'b1, k);
        exp_pass(k, 4, 2);
        tick(); start = 1'b0;
        wait_neg(k + 1); chk("t2_rd_c1", rdAddr, 0);
        tick(); stall = 1'b1;
        wait_neg(k + 2); chk("t2_rd_c2", rdAddr, 1);
        tick();
        wait_neg(k + 3); chk("t2_rd_c3", rdAddr, 1);
        tick(); stall = 1'b0;
        wait_neg(k + 4); chk("t2_rd_c4", rdAddr, 1);
        wait_neg(k + 5); chk("t2_rd_c5", rdAddr, 2);
        wait_neg(k + 6); chk("t2_rd_c6", rdAddr, 3);
        wait_neg(k + 11);
        chk("t2_rbSel_after", rbSel, 0);

        // 3: empty pass, no swap
        start_pass(0, 1'b0, 1'b0, k);
        exp_done(k + 1);
        tick(); start = 1'b0;
        wait_neg(k + 1); chk("t3_busy_swap", busy, 1);
        wait_neg(k + 2);
        chk("t3_rbSel", rbSel, 0);
        chk("t3_idle", busy, 0);
        chk("t3_doPooling", doPooling, 0);

        // 4: host IO in IDLE, then dropped while starting/busy
        tick(); ioEn = 1'b1; ioWrite = 1'b1; ioAddress = 7'd5;
        wait_neg(cyc);
        chk("t4_io_rdAddr", rdAddr, 5);
        chk("t4_io_nRWrite", nRWrite, 1);
        start_pass(3, 1'b0, 1'b1, k);
        wait_neg(k);
        chk("t4_start_prio_nRWrite", nRWrite, 0);
        chk("t4_start_prio_rdAddr", rdAddr, 0);
        exp_pass(k, 3, 0);
        tick(); start = 1'b0;
        wait_neg(k + 2);
        chk("t4_busy_nRWrite", nRWrite, 0);
        chk("t4_busy_rdAddr", rdAddr, 1);
        wait_neg(k + 7);
        chk("t4_swap_nRWrite", nRWrite, 0);
        tick(); ioEn = 1'b0; ioWrite = 1'b0; ioAddress = '0;
        wait_neg(k + 8);
        chk("t4_rbSel_after", rbSel, 1);

        // 6: back-to-back passes, start during a pass ignored
        start_pass(2, 1'b1, 1'b1, k);
        exp_pass(k, 2, 0);
        tick(); start = 1'b0;
        tick(); start = 1'b1; numWords = 7'd5; doPoolingIn = 1'b0;
        tick(); start = 1'b0;
        wait_neg(k + 6);
        chk("t6_rbSel_at_done", rbSel, 1);
        start_pass(1, 1'b1, 1'b1, k2);
        exp_pass(k2, 1, 0);
        wait_neg(k2);
        chk("t6_rbSel_mid", rbSel, 0);
        tick(); start = 1'b0;
        wait_neg(k2 + 6);
        chk("t6_rbSel_end", rbSel, 1);
        chk("t6_doPooling_held", doPooling, 1);

        // 5: reset mid-READ aborts without done
        start_pass(6, 1'b1, 1'b1, k);
        tick(); start = 1'b0;
        tick();
        tick(); reset = 1'b1;
        wait_neg(k + 3); chk("t5_busy_before", busy, 1);
        tick(); reset = 1'b0;
        wait_neg(k + 4);
        chk("t5_busy", busy, 0);
        chk("t5_rbSel", rbSel, 0);
        chk("t5_doPooling", doPooling, 0);
        chk("t5_nWWrite", nWWrite, 0);
        wait_neg(k + 20);

        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
